// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/response bundle between the issue stage and the M-extension unit
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            kill;
    logic            ready;
    logic            result_valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, operand_a, operand_b, kill,
        input  ready, result_valid, result
    );

    modport slave (
        input  start, funct3, operand_a, operand_b, kill,
        output ready, result_valid, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, one bit per cycle, fixed latency
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic              neg_a;
    logic              neg_b;
    logic              b_zero;
    logic [XLEN-1:0]   m;
    logic [2*XLEN-1:0] acc;

    logic              a_signed;
    logic              b_signed;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;

    always_comb begin
        a_signed = bus.funct3 inside {3'd1, 3'd2, 3'd4, 3'd6};
        b_signed = bus.funct3 inside {3'd1, 3'd4, 3'd6};
        a_mag    = (a_signed && bus.operand_a[XLEN-1]) ? -bus.operand_a : bus.operand_a;
        b_mag    = (b_signed && bus.operand_b[XLEN-1]) ? -bus.operand_b : bus.operand_b;
    end

    // acc = {partial product, multiplier} for multiply, {remainder, dividend/quotient} for divide
    logic [XLEN:0]     sum;
    logic [XLEN:0]     rem_sh;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_sub;
    logic [2*XLEN-1:0] acc_nxt;

    always_comb begin
        sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
        rem_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        rem_ge  = rem_sh >= {1'b0, m};
        rem_sub = rem_sh[XLEN-1:0] - m;
        if (op[2]) begin
            acc_nxt = {(rem_ge ? rem_sub : rem_sh[XLEN-1:0]), acc[XLEN-2:0], rem_ge};
        end else begin
            acc_nxt = {sum, acc[XLEN-1:1]};
        end
    end

    // Signed overflow needs no special handling: |min|/1 negated wraps back to min, remainder 0.
    // A zero divisor naturally leaves the dividend magnitude as remainder, so only the quotient is forced.
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rmd;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        prod = (neg_a ^ neg_b) ? -acc_nxt : acc_nxt;
        quo  = (neg_a ^ neg_b) ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rmd  = neg_a ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        final_res = rmd;
        case (op)
            3'd0:                final_res = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    final_res = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:          final_res = b_zero ? {XLEN{1'b1}} : quo;
            default:             final_res = rmd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.ready        <= 1'b1;
            bus.result_valid <= 1'b0;
            bus.result       <= '0;
        end else begin
            bus.result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.kill) begin
                        state     <= RUN;
                        bus.ready <= 1'b0;
                        cnt       <= '0;
                        op        <= bus.funct3;
                        neg_a     <= a_signed && bus.operand_a[XLEN-1];
                        neg_b     <= b_signed && bus.operand_b[XLEN-1];
                        b_zero    <= (bus.operand_b == '0);
                        if (bus.funct3[2]) begin
                            m   <= b_mag;
                            acc <= {{XLEN{1'b0}}, a_mag};
                        end else begin
                            m   <= a_mag;
                            acc <= {{XLEN{1'b0}}, b_mag};
                        end
                    end
                end
                RUN: begin
                    if (bus.kill) begin
                        state     <= IDLE;
                        bus.ready <= 1'b1;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(XLEN-1)) begin
                            state            <= DONE;
                            bus.result       <= final_res;
                            bus.result_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus.ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32)) bus();

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // mode 0 plain, 1 start pulsed while busy, 2 kill on RUN cycle 10, 3 reset on RUN cycle 10
    task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int mode);
        logic [31:0] vres;
        logic [31:0] end_res;
        logic        rdy_after;
        int          vcnt;
        int          vcyc;
        int          rdy_bad;
        int          lim;
        vres = '0; rdy_after = 1'b0; vcnt = 0; vcyc = 0; rdy_bad = 0;
        lim = (mode >= 2) ? 10 : 33;
        bus.start = 1'b1; bus.funct3 = f; bus.operand_a = a; bus.operand_b = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.funct3 = f ^ 3'b101; bus.operand_a = ~a; bus.operand_b = b + 32'd3;
        for (int c = 1; c <= 34; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 6)  bus.start = 1'b0;
            if (c == 11) begin bus.kill = 1'b0; reset = 1'b0; end
            if (bus.result_valid) begin vcnt++; vcyc = c; vres = bus.result; end
            if (c <= lim && bus.ready) rdy_bad++;
            if (c == lim + 1) rdy_after = bus.ready;
            if (c == 5 && mode == 1) begin
                bus.start = 1'b1; bus.funct3 = 3'd0; bus.operand_a = 32'h11; bus.operand_b = 32'h22;
            end
            if (c == 10 && mode == 2) bus.kill = 1'b1;
            if (c == 10 && mode == 3) reset = 1'b1;
        end
        end_res = bus.result;
        if (mode < 2) begin
            chk($sformatf("%s valid_count", name), 32'(vcnt), 32'd1);
            chk($sformatf("%s valid_cycle", name), 32'(vcyc), 32'd33);
            chk($sformatf("%s result", name), vres, exp);
        end else begin
            chk($sformatf("%s valid_count", name), 32'(vcnt), 32'd0);
        end
        chk($sformatf("%s ready_low", name), 32'(rdy_bad), 32'd0);
        chk($sformatf("%s ready_rise", name), {31'd0, rdy_after}, 32'd1);
        chk($sformatf("%s result_held", name), end_res, exp);
    endtask

    initial begin
        vecs[0]  = '{"mul_7_m3",       3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
        vecs[1]  = '{"mulh_min_min",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000};
        vecs[2]  = '{"mulhu_max_max",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[3]  = '{"mulhsu_m1_2",    3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
        vecs[4]  = '{"div_m7_2",       3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
        vecs[5]  = '{"rem_m7_2",       3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
        vecs[6]  = '{"divu_100_7",     3'd5, 32'd100,      32'd7,        32'd14};
        vecs[7]  = '{"remu_100_7",     3'd7, 32'd100,      32'd7,        32'd2};
        vecs[8]  = '{"divu_5_0",       3'd5, 32'd5,        32'd0,        32'hFFFFFFFF};
        vecs[9]  = '{"rem_5_0",        3'd6, 32'd5,        32'd0,        32'd5};
        vecs[10] = '{"div_ovf",        3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vecs[11] = '{"rem_ovf",        3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0};
        vecs[12] = '{"div_m7_0",       3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF};
        vecs[13] = '{"rem_m7_0",       3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9};
        vecs[14] = '{"mulh_7_m3",      3'd1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[15] = '{"remu_5_0",       3'd7, 32'd5,        32'd0,        32'd5};

        reset = 1'b1;
        bus.start = 1'b0; bus.kill = 1'b0; bus.funct3 = 3'd0;
        bus.operand_a = '0; bus.operand_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ready", {31'd0, bus.ready}, 32'd1);
        chk("reset result_valid", {31'd0, bus.result_valid}, 32'd0);
        chk("reset result", bus.result, 32'd0);
        reset = 1'b0;

        // each do_op returns on cycle 34, so consecutive calls accept at the minimum spacing
        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, 0);
        end

        do_op("busy_mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1);
        do_op("kill_run10", 3'd1, 32'h12345678, 32'h9ABCDEF0, 32'hFFFFFFEB, 2);
        do_op("mulhu_3_5_after_kill", 3'd3, 32'd3, 32'd5, 32'd0, 0);
        do_op("divu_after", 3'd5, 32'd100, 32'd7, 32'd14, 0);
        do_op("reset_run10", 3'd1, 32'h12345678, 32'h9ABCDEF0, 32'd0, 3);
        do_op("mulhu_3_5_after_reset", 3'd3, 32'd3, 32'd5, 32'd0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised integer multiply/divide unit implementing the RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It is the multi-cycle companion to the single-cycle ALU. The decode stage issues an M-extension R-type instruction (funct7 = 7'h01) to this block instead of the ALU, and the core stalls until the result is returned. Each operation uses a one-bit-per-cycle shift-add or restoring-subtract datapath with fixed latency and a simple start/ready/result_valid handshake.

## Interface
Parameters:
- XLEN, 32, operand and result width; any even value ≥ 8.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; accepted only on a rising edge where start && ready && !kill.
- funct3  in  3  operation select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- operand_a  in  XLEN  rs1 value (multiplicand / dividend).
- operand_b  in  XLEN  rs2 value (multiplier / divisor).
- kill  in  1  pipeline flush; aborts any in-flight operation.
- ready  out  1  high only in IDLE; the unit can accept a request.
- result_valid  out  1  single-cycle pulse marking result as valid.
- result  out  XLEN  operation result; held from the DONE cycle until the next accept.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on accept.
  - RUN→DONE after exactly XLEN RUN cycles (counter 0..XLEN-1).
  - DONE→IDLE unconditionally.
- Accept: latch funct3, compute operand magnitudes, and record both sign flags.
  - Signed operands: a for MULH, MULHSU, DIV, REM; b for MULH, DIV, REM.
  - All other operands are treated as unsigned.
- Multiply:
  - Datapath holds a 2·XLEN-bit accumulator and shifts one multiplier bit per RUN cycle.
  - In DONE, the product is negated if the signs differ.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide:
  - Restoring algorithm on magnitudes, one quotient bit per RUN cycle.
  - Quotient is negated if the signs differ (DIV only).
  - Remainder takes the dividend's sign (REM only).
- Special cases are resolved in DONE; latency is unchanged for them.
  - Divisor = 0: DIV/DIVU return all ones; REM/REMU return operand_a.
  - Signed overflow (a = 1 followed by XLEN-1 zeros, b = all ones) on DIV: return a; on REM: return 0.
- Request rules:
  - start while ready is low is ignored, with no queueing.
  - Operand and funct3 changes after the accept edge have no effect.
- kill:
  - In RUN or DONE, the next state is IDLE and result_valid is forced low in that cycle.
  - result keeps its previous value.
  - In IDLE, kill blocks acceptance.
- reset (synchronous):
  - State → IDLE, ready = 1, result_valid = 0, result = 0, counter = 0.
  - Reset mid-operation behaves like kill, except that result is also cleared.

## Timing
- Accept edge = E0. RUN occupies the cycles after E0 through E_XLEN. DONE is the cycle after edge E_XLEN.
- result_valid is high in that DONE cycle only, i.e. XLEN+1 cycles after the accept cycle (33 for XLEN = 32). result is valid in the same cycle.
- ready:
  - Falls in the cycle after E0.
  - Stays low through DONE.
  - Rises in the cycle after DONE.
- Minimum spacing between back-to-back accepts: XLEN+2 cycles.
- Outputs are registered; there is no combinational path from inputs to ready, result_valid or result.

## Test plan
1. MUL 7 × 0xFFFFFFFD (-3) → result 0xFFFFFFEB. result_valid pulses exactly once, 33 cycles after accept; ready is low for cycles 1–33.
2. Multiply-high variants:
   - MULH 0x80000000 × 0x80000000 → 0x40000000.
   - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
3. Division:
   - DIV -7/2 → 0xFFFFFFFD.
   - REM -7/2 → 0xFFFFFFFF.
   - DIVU 100/7 → 14.
   - REMU 100/7 → 2.
4. Special cases:
   - DIVU 5/0 → 0xFFFFFFFF.
   - REM 5/0 → 5.
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
   - REM of the same operands → 0.
   - Every case takes the standard 33-cycle latency.
5. Abort and recovery:
   - kill on RUN cycle 10 → no result_valid; ready is high 1 cycle later; the prior result is unchanged; a following MULHU 3×5 returns 0.
   - Repeat the scenario with reset in place of kill → result = 0.
6. Busy and back-to-back:
   - start pulsed while busy with different operands → ignored; the original result is returned.
   - Two accepts spaced 34 cycles apart both complete correctly.
